// File: rtl/hit_reaction.sv
// Defender hit reaction: accepts a hit, shakes and flashes the sprite, then drains
// HP one point per advanced animation frame while handshaking redraws with the drawer.
module hit_reaction #(
    parameter int BASE_X       = 230,
    parameter int BASE_Y       = 40,
    parameter int SHAKE_AMP    = 4,
    parameter int SHAKE_FRAMES = 8,
    parameter int MAX_HP       = 100
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_frame_pulse,
    input  logic       i_hit_valid,
    input  logic [6:0] i_hit_damage,
    output logic       o_hit_ready,
    output logic [8:0] o_defender_x,
    output logic [7:0] o_defender_y,
    output logic       o_sprite_visible,
    output logic [6:0] o_hp,
    output logic       o_hp_zero,
    output logic       o_draw_req,
    input  logic       i_draw_done,
    output logic       o_reaction_done
);

    typedef enum logic [1:0] {
        IDLE,
        SHAKE,
        DRAIN,
        DONE
    } state_t;

    localparam logic [8:0] X_REST   = 9'(BASE_X);
    localparam logic [8:0] X_RIGHT  = 9'(BASE_X + SHAKE_AMP);
    localparam logic [8:0] X_LEFT   = 9'(BASE_X - SHAKE_AMP);
    localparam logic [7:0] Y_REST   = 8'(BASE_Y);
    localparam logic [6:0] HP_INIT  = 7'(MAX_HP);
    localparam logic [5:0] CNT_LAST = 6'(SHAKE_FRAMES - 1);

    state_t     r_state;
    logic [6:0] r_hp;
    logic [6:0] r_pending;
    logic [5:0] r_frame_cnt;
    logic [8:0] r_x;
    logic       r_visible;
    logic       r_draw_req;

    state_t     w_state_next;
    logic [6:0] w_hp_next;
    logic [6:0] w_pending_next;
    logic [5:0] w_frame_cnt_next;
    logic [8:0] w_x_next;
    logic       w_visible_next;
    logic       w_draw_req_next;
    logic       w_hit_ready;
    logic       w_advance;

    assign w_hit_ready = (r_state == IDLE) && (r_hp != 7'd0);
    // A frame only advances once the drawer has consumed the previous redraw.
    assign w_advance   = i_frame_pulse && !r_draw_req;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_hp        <= HP_INIT;
            r_pending   <= 7'd0;
            r_frame_cnt <= 6'd0;
            r_x         <= X_REST;
            r_visible   <= 1'b1;
            r_draw_req  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hp        <= w_hp_next;
            r_pending   <= w_pending_next;
            r_frame_cnt <= w_frame_cnt_next;
            r_x         <= w_x_next;
            r_visible   <= w_visible_next;
            r_draw_req  <= w_draw_req_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_hp_next        = r_hp;
        w_pending_next   = r_pending;
        w_frame_cnt_next = r_frame_cnt;
        w_x_next         = r_x;
        w_visible_next   = r_visible;
        w_draw_req_next  = r_draw_req;

        if (i_draw_done) begin
            w_draw_req_next = 1'b0;
        end

        case (r_state)
            IDLE: begin
                if (i_hit_valid && w_hit_ready) begin
                    // Clamp so the drain can never take HP below zero.
                    w_pending_next   = (i_hit_damage < r_hp) ? i_hit_damage : r_hp;
                    w_frame_cnt_next = 6'd0;
                    w_state_next     = SHAKE;
                end
            end
            SHAKE: begin
                if (w_advance) begin
                    w_draw_req_next  = 1'b1;
                    w_frame_cnt_next = r_frame_cnt + 6'd1;
                    if (r_frame_cnt == CNT_LAST) begin
                        w_x_next       = X_REST;
                        w_visible_next = 1'b1;
                        w_state_next   = DRAIN;
                    end else begin
                        w_x_next       = r_frame_cnt[0] ? X_LEFT : X_RIGHT;
                        w_visible_next = r_frame_cnt[0];
                    end
                end
            end
            DRAIN: begin
                if (w_advance) begin
                    if (r_pending != 7'd0) begin
                        w_hp_next       = r_hp - 7'd1;
                        w_pending_next  = r_pending - 7'd1;
                        w_draw_req_next = 1'b1;
                    end else begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign o_hit_ready      = w_hit_ready;
    assign o_defender_x     = r_x;
    assign o_defender_y     = Y_REST;
    assign o_sprite_visible = r_visible;
    assign o_hp             = r_hp;
    assign o_hp_zero        = (r_hp == 7'd0);
    assign o_draw_req       = r_draw_req;
    assign o_reaction_done  = (r_state == DONE);

endmodule

// File: tb/tb_hit_reaction.sv
// Bench for hit_reaction: directed scenarios plus random traffic, compared every
// cycle against a model that expands each accepted hit into a list of frame outcomes.
module tb_hit_reaction;

    localparam int BASE_X       = 230;
    localparam int BASE_Y       = 40;
    localparam int SHAKE_AMP    = 4;
    localparam int SHAKE_FRAMES = 8;
    localparam int MAX_HP       = 100;

    logic       clock = 1'b0;
    logic       reset;
    logic       frame_pulse;
    logic       hit_valid;
    logic [6:0] hit_damage;
    logic       draw_done;
    logic       hit_ready;
    logic [8:0] defender_x;
    logic [7:0] defender_y;
    logic       sprite_visible;
    logic [6:0] hp;
    logic       hp_zero;
    logic       draw_req;
    logic       reaction_done;

    always #5 clock = ~clock;

    hit_reaction #(
        .BASE_X       (BASE_X),
        .BASE_Y       (BASE_Y),
        .SHAKE_AMP    (SHAKE_AMP),
        .SHAKE_FRAMES (SHAKE_FRAMES),
        .MAX_HP       (MAX_HP)
    ) dut (
        .i_clock          (clock),
        .i_reset          (reset),
        .i_frame_pulse    (frame_pulse),
        .i_hit_valid      (hit_valid),
        .i_hit_damage     (hit_damage),
        .o_hit_ready      (hit_ready),
        .o_defender_x     (defender_x),
        .o_defender_y     (defender_y),
        .o_sprite_visible (sprite_visible),
        .o_hp             (hp),
        .o_hp_zero        (hp_zero),
        .o_draw_req       (draw_req),
        .i_draw_done      (draw_done),
        .o_reaction_done  (reaction_done)
    );

    int assertCount = 0;
    int failCount   = 0;

    // One entry per advancing frame pulse of a reaction; the final entry ends it.
    typedef struct {
        int x;
        int vis;
        int hp;
        bit last;
    } step_t;

    step_t stepQ[$];
    int    mHp, mX, mVis;
    bit    mBusy, mDrawReq, mDone;

    task automatic checkOutput(input string tag, input int got, input int exp);
        assertCount++;
        if (got != exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void modelReset();
        stepQ.delete();
        mHp      = MAX_HP;
        mX       = BASE_X;
        mVis     = 1;
        mBusy    = 0;
        mDrawReq = 0;
        mDone    = 0;
    endfunction

    function automatic void modelAccept(input int dmg);
        int    taken;
        step_t s;
        taken = (dmg < mHp) ? dmg : mHp;
        for (int k = 0; k < SHAKE_FRAMES; k++) begin
            s.hp   = mHp;
            s.last = 0;
            if (k == SHAKE_FRAMES - 1) begin
                s.x   = BASE_X;
                s.vis = 1;
            end else begin
                s.x   = (k % 2 == 0) ? BASE_X + SHAKE_AMP : BASE_X - SHAKE_AMP;
                s.vis = k % 2;
            end
            stepQ.push_back(s);
        end
        for (int d = 1; d <= taken; d++) begin
            s.x    = BASE_X;
            s.vis  = 1;
            s.hp   = mHp - d;
            s.last = 0;
            stepQ.push_back(s);
        end
        s.x    = BASE_X;
        s.vis  = 1;
        s.hp   = mHp - taken;
        s.last = 1;
        stepQ.push_back(s);
        mBusy = 1;
    endfunction

    function automatic void modelEdge(input bit fp, input bit hv, input int dmg,
                                      input bit dd, input bit rst);
        step_t s;
        if (rst) begin
            modelReset();
        end else if (mDone) begin
            mDone = 0;
            mBusy = 0;
        end else if (!mBusy) begin
            if (hv && mHp != 0) modelAccept(dmg);
        end else if (fp && !mDrawReq) begin
            s    = stepQ.pop_front();
            mX   = s.x;
            mVis = s.vis;
            mHp  = s.hp;
            if (s.last) mDone = 1;
            else        mDrawReq = 1;
        end else if (dd) begin
            mDrawReq = 0;
        end
    endfunction

    task automatic applyStimulus(input bit fp, input bit hv, input int dmg,
                                 input bit dd, input bit rst);
        frame_pulse = fp;
        hit_valid   = hv;
        hit_damage  = 7'(dmg);
        draw_done   = dd;
        reset       = rst;
        @(posedge clock);
        modelEdge(fp, hv, dmg, dd, rst);
        #1;
        checkOutput("defender_x", int'(defender_x), mX);
        checkOutput("defender_y", int'(defender_y), BASE_Y);
        checkOutput("sprite_visible", int'(sprite_visible), mVis);
        checkOutput("hp", int'(hp), mHp);
        checkOutput("hp_zero", int'(hp_zero), (mHp == 0) ? 1 : 0);
        checkOutput("draw_req", int'(draw_req), int'(mDrawReq));
        checkOutput("hit_ready", int'(hit_ready), (!mBusy && mHp != 0) ? 1 : 0);
        checkOutput("reaction_done", int'(reaction_done), int'(mDone));
    endtask

    // Frame pulse on even cycles, drawer acknowledge on the following cycle.
    task automatic pumpFrames(input int cycles, input bit hv, input int dmg);
        for (int i = 0; i < cycles; i++) begin
            applyStimulus(i % 2 == 0, hv, dmg, i % 2 == 1, 0);
        end
    endtask

    task automatic runReaction(input int dmg, input int effDmg, input bit holdValid);
        applyStimulus(0, 1, dmg, 0, 0);
        pumpFrames(2 * (SHAKE_FRAMES + effDmg + 1) + 6, holdValid, dmg);
    endtask

    int doneSeen;

    initial begin
        frame_pulse = 0;
        hit_valid   = 0;
        hit_damage  = 0;
        draw_done   = 0;
        reset       = 1;
        modelReset();

        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 0, 0);

        runReaction(3, 3, 0);
        runReaction(2, 2, 1);

        applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 1, 5, 0, 0);
        pumpFrames(22, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);

        applyStimulus(1, 1, 0, 0, 0);
        pumpFrames(2 * (SHAKE_FRAMES + 1) + 6, 0, 0);

        applyStimulus(0, 1, 4, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            applyStimulus(1, 0, 0, 0, 0);
        end
        applyStimulus(0, 0, 0, 1, 0);
        pumpFrames(2 * (SHAKE_FRAMES + 4 + 1) + 6, 0, 0);

        applyStimulus(0, 0, 0, 0, 1);
        runReaction(95, 95, 0);
        runReaction(120, 5, 0);
        for (int i = 0; i < 20; i++) applyStimulus(i % 2 == 0, 1, 10, i % 2 == 1, 0);

        applyStimulus(0, 0, 0, 0, 1);
        doneSeen = 0;
        for (int i = 0; i < 4000; i++) begin
            int sel;
            int dmg;
            sel = int'($urandom_range(0, 9));
            dmg = (sel == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 6));
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, dmg,
                          $urandom_range(0, 1) == 1, $urandom_range(0, 599) == 0);
            if (reaction_done) doneSeen++;
        end
        checkOutput("random_reactions_completed", (doneSeen > 5) ? 1 : 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/hit_reaction.md
Name: hit_reaction

Overview:
- Defender-side counterpart to the attack animations: takes a hit from an attack sequencer, shakes and flashes the defending Pokemon's sprite, then drains its HP one point per animation frame.
- Sits between the battle controller and the defender's sprite drawer and HP bar drawer.
- Outputs sprite position, visibility and HP, and requests a redraw once per advanced frame.

Parameters:
- BASE_X, 230, defender sprite rest x (9-bit); requires SHAKE_AMP <= BASE_X <= 319-SHAKE_AMP.
- BASE_Y, 40, defender sprite y (8-bit), constant.
- SHAKE_AMP, 4, horizontal shake offset in pixels.
- SHAKE_FRAMES, 8, number of advanced frames in the shake phase (2..63).
- MAX_HP, 100, HP after reset (1..127).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_pulse  in  1  one-cycle pulse per animation frame
- hit_valid  in  1  attacker presents a hit
- hit_damage  in  7  damage points, sampled on acceptance
- hit_ready  out  1  block can accept a hit
- defender_x  out  9  sprite x to the drawer
- defender_y  out  8  sprite y, always BASE_Y
- sprite_visible  out  1  0 = drawer blanks sprite (flash)
- hp  out  7  current HP
- hp_zero  out  1  hp == 0 (fainted)
- draw_req  out  1  redraw request, held until draw_done
- draw_done  in  1  drawer finished, one-cycle pulse
- reaction_done  out  1  one-cycle pulse when the reaction completes

Behaviour:
- Reset (synchronous, active-high) from any state forces:
  - state IDLE, hp=MAX_HP, pending=0, frame_cnt=0
  - defender_x=BASE_X, sprite_visible=1, draw_req=0, reaction_done=0
  - No partial damage survives a reset.
- hit_ready is combinational: 1 iff state==IDLE and hp!=0. A hit is accepted on a clock edge where hit_valid && hit_ready.
- On acceptance:
  - pending <= min(hit_damage, hp); over-damage is clamped.
  - State goes to SHAKE and frame_cnt <= 0.
  - A frame_pulse in the acceptance cycle is ignored.
- hit_valid while hit_ready=0 is ignored and not queued. The attacker must hold hit_valid until it sees ready.
- Advance: a frame_pulse in SHAKE or DRAIN with draw_req=0 advances one step. A frame_pulse while draw_req=1 is dropped (no advance, no error).
- Every advance sets draw_req=1 on the same edge as the output update. draw_req clears on the edge draw_done=1. draw_done while draw_req=0 is ignored.
- SHAKE:
  - On advance k (0-based), frame_cnt <= k+1.
  - defender_x = BASE_X+SHAKE_AMP when k is even, BASE_X-SHAKE_AMP when k is odd.
  - sprite_visible = k odd; it is 0 on the first shake frame.
  - On the advance where k+1 == SHAKE_FRAMES: defender_x <= BASE_X, sprite_visible <= 1, state -> DRAIN.
- DRAIN:
  - On advance with pending!=0: hp <= hp-1, pending <= pending-1.
  - On advance with pending==0: state -> DONE; draw_req is not set on this advance.
  - Zero damage (or clamp to 0) therefore passes through DRAIN with one advance.
- DONE: reaction_done=1 for exactly one cycle, then IDLE.
- All arithmetic is 9-bit for x and 7-bit for hp and pending. Parameter limits guarantee no wrap.
- hp_zero is combinational from hp. Once hp==0, hit_ready stays 0 until reset.
- Latency from acceptance to reaction_done, with immediate draw_done: SHAKE_FRAMES + pending + 1 frame pulses, plus one cycle.

Test Plan:
- Reset, then idle for 20 cycles -> hp=100, hp_zero=0, hit_ready=1, defender_x=230, defender_y=40, sprite_visible=1, draw_req=0.
- Hit with damage 3; 12 frame_pulses, each acked with draw_done one cycle later ->
  - defender_x sequence 234, 226, 234, 226, 234, 226, 234, 230
  - sprite_visible sequence 0, 1, 0, 1, 0, 1, 0, 1
  - hp 99, 98, 97
  - reaction_done pulses once, then hit_ready=1.
- Hit with damage 120 while hp=5 -> drains to hp=0, hp_zero=1. Further hit_valid is never accepted.
- Hold draw_done low for 3 frame_pulses after the first shake frame -> defender_x stays 234 and frame_cnt stays 1. Advancing resumes only after draw_done.
- Hit_valid asserted continuously during SHAKE -> no second acceptance until IDLE.
- Assert reset mid-DRAIN (hp=97, pending=2) -> next cycle hp=100, IDLE, defender_x=230, draw_req=0.
- Hit with damage 0, and hit accepted in the same cycle as a frame_pulse -> that frame_pulse is ignored; full shake runs; hp unchanged; reaction_done after SHAKE_FRAMES+1 advancing pulses.
